// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// spi_reg_pkg -- shared types, default parameters and frame sizing for the
// SPI register bank.                                         Revision: 1.0
// ============================================================================
package spi_reg_pkg;

  localparam int c_DEF_NUM_REGS = 5;
  localparam int c_DEF_ADDR_W   = 7;
  localparam int c_DEF_DATA_W   = 8;
  localparam int c_DEF_RST_VAL  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge -- two-flop synchroniser with single-cycle rise/fall pulses.
//                                                            Revision: 1.0
// ============================================================================
module spi_sync_edge
  import spi_reg_pkg::*;
#(
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_LVL;
      r_sync <= RST_LVL;
      r_prev <= RST_LVL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// spi_reg_bank -- SPI (mode 0) slave register bank, fully clocked by clk.
//                                                            Revision: 1.0
// ============================================================================
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                NUM_REGS = c_DEF_NUM_REGS,
  parameter int                ADDR_W   = c_DEF_ADDR_W,
  parameter int                DATA_W   = c_DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL  = DATA_W'(c_DEF_RST_VAL)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int              c_FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int              c_CNT_W    = $clog2(c_FRAME_W);
  localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;
  logic w_unused_sync;

  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_async(copi),
    .o_level(w_copi_lvl), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  // Chip select resets to "selected" so a frame already under way when reset
  // releases yields no falling edge and is ignored until the next one.
  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_async(ncs),
    .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  assign w_unused_sync = ^{w_sclk_lvl, w_copi_rise, w_copi_fall};

  state_t              r_state, w_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W:0]     r_cmd;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_shift;
  logic                r_bad;
  logic                r_wr_strobe;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_rise, w_fall;
  logic [ADDR_W:0]     w_cmd_next;
  logic                w_cmd_done, w_data_done;
  logic                w_addr_ok, w_commit;
  logic [DATA_W-1:0]   w_rd_val;

  assign w_rise      = w_sclk_rise & ~w_ncs_lvl;
  assign w_fall      = w_sclk_fall & ~w_ncs_lvl;
  assign w_cmd_next  = (ADDR_W+1)'({r_cmd, w_copi_lvl});
  assign w_cmd_done  = (r_state == ST_CMD) && w_rise && (r_cnt == c_CNT_W'(ADDR_W));
  assign w_data_done = ((r_state == ST_WDATA) || (r_state == ST_RDATA)) && w_rise &&
                       (r_cnt == c_CNT_W'(DATA_W - 1));
  assign w_addr_ok   = {1'b0, r_cmd[ADDR_W-1:0]} < c_NUM_REGS;
  assign w_commit    = w_ncs_rise && (r_state == ST_HOLD) && r_cmd[ADDR_W] &&
                       !r_bad && w_addr_ok;

  // Unmatched (out-of-range) addresses read back as zero.
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_cmd_next[ADDR_W-1:0] == ADDR_W'(k)) w_rd_val = r_regs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_ncs_fall) begin
      w_next = ST_CMD;
    end else if (w_ncs_rise) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_CMD:   if (w_cmd_done) w_next = w_cmd_next[ADDR_W] ? ST_WDATA : ST_RDATA;
        ST_WDATA: if (w_data_done) w_next = ST_HOLD;
        ST_RDATA: if (w_data_done) w_next = ST_HOLD;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_wdata     <= '0;
      r_shift     <= '0;
      r_bad       <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_ncs_fall) begin
        r_cnt   <= '0;
        r_cmd   <= '0;
        r_shift <= '0;
        r_bad   <= 1'b0;
      end else if (w_ncs_rise) begin
        if (w_commit) begin
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= r_cmd[ADDR_W-1:0];
        end
      end else begin
        case (r_state)
          ST_CMD: begin
            if (w_rise) begin
              r_cmd <= w_cmd_next;
              r_cnt <= w_cmd_done ? '0 : r_cnt + c_CNT_W'(1);
              if (w_cmd_done && !w_cmd_next[ADDR_W]) r_shift <= w_rd_val;
            end
          end
          ST_WDATA: begin
            if (w_rise) begin
              r_wdata <= DATA_W'({r_wdata, w_copi_lvl});
              r_cnt   <= w_data_done ? '0 : r_cnt + c_CNT_W'(1);
            end
          end
          ST_RDATA: begin
            if (w_rise) begin
              r_cnt <= w_data_done ? '0 : r_cnt + c_CNT_W'(1);
            end else if (w_fall && (r_cnt != '0)) begin
              // MSB stays put until the first data bit has been sampled.
              r_shift <= r_shift << 1;
            end
          end
          ST_HOLD: begin
            if (w_rise) r_bad <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RST_VAL;
    end else if (w_commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_cmd[ADDR_W-1:0] == ADDR_W'(k)) r_regs[k] <= r_wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign cipo_oe   = (r_state == ST_RDATA) || ((r_state == ST_HOLD) && !r_cmd[ADDR_W]);
  assign cipo      = cipo_oe & r_shift[DATA_W-1];
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_bank -- scoreboard bench: driver pushes expectations, monitors
// pop them on wr_strobe pulses and on each chip-select frame end. Rev: 1.0
// ============================================================================
module tb_spi_reg_bank;

  localparam int NR   = 5;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int FW   = 1 + AW + DW;
  localparam int HALF = 60;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [NR*DW-1:0] regs;
  } wr_exp_t;

  typedef struct {
    int          nbits;
    logic [31:0] oe;
    bit          chk;
    logic [DW-1:0] data;
  } frm_exp_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             sclk  = 1'b0;
  logic             copi  = 1'b0;
  logic             ncs   = 1'b1;
  logic             cipo;
  logic             cipo_oe;
  logic [NR*DW-1:0] regs;
  logic             wr_strobe;
  logic [AW-1:0]    wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_regs [NR];
  wr_exp_t  q_wr  [$];
  frm_exp_t q_frm [$];

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_regs[k];
    return v;
  endfunction

  task automatic check_regs(input string name);
    check(name, 64'(regs), 64'(model_flat()));
  endtask

  // Drive one frame; bits past FW are random filler.
  task automatic send_frame(input logic [FW-1:0] v, input int nbits,
                            input int gap, input bit rst_mid);
    ncs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      copi = (i < FW) ? v[FW-1-i] : 1'($urandom);
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
    if (rst_mid) begin
      #20 rst_n = 1'b0;
      #30 rst_n = 1'b1;
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      #20;
    end
    #HALF ncs = 1'b1;
    copi = 1'b0;
    #gap;
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data, input int nbits,
                          input int gap, input bit rst_mid);
    frm_exp_t f;
    wr_exp_t  w;
    if (nbits == FW && addr < NR && !rst_mid) begin
      m_regs[addr] = data;
      w.addr = AW'(addr);
      w.regs = model_flat();
      q_wr.push_back(w);
    end
    f.nbits = nbits;
    f.oe    = '0;
    f.chk   = 1'b0;
    f.data  = '0;
    q_frm.push_back(f);
    send_frame({1'b1, AW'(addr), data}, nbits, gap, rst_mid);
  endtask

  task automatic do_read(input int addr, input int nbits, input int gap);
    frm_exp_t f;
    f.nbits = nbits;
    f.oe    = '0;
    for (int i = 1 + AW; i < nbits && i < 32; i++) f.oe[i] = 1'b1;
    f.chk   = (nbits >= FW);
    f.data  = (addr < NR) ? m_regs[addr] : '0;
    q_frm.push_back(f);
    send_frame({1'b0, AW'(addr), DW'(8'h00)}, nbits, gap, 1'b0);
  endtask

  // Write-side monitor: every strobe must match a queued commit.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cipo_oe !== 1'b1) check("cipo_low_when_not_oe", 64'(cipo), 64'd0);
      if (wr_strobe === 1'b1) begin
        if (q_wr.size() == 0) begin
          check("unexpected_wr_strobe", 64'(wr_addr), 64'hFFFF);
        end else begin
          wr_exp_t e;
          e = q_wr.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("regs_at_strobe", 64'(regs), 64'(e.regs));
        end
      end
    end
  end

  // Frame monitor: records cipo/cipo_oe at each sclk rise of a frame.
  initial begin : frame_mon
    forever begin : one_frame
      int          n;
      logic [31:0] oe_v;
      logic [31:0] ci_v;
      logic [DW-1:0] rd;
      frm_exp_t    e;
      @(negedge ncs);
      n    = 0;
      oe_v = '0;
      ci_v = '0;
      while (ncs === 1'b0) begin
        @(posedge sclk or posedge ncs);
        if (ncs === 1'b0 && n < 32) begin
          oe_v[n] = cipo_oe;
          ci_v[n] = cipo;
          n++;
        end
      end
      if (q_frm.size() == 0) begin
        check("unexpected_frame", 64'(n), 64'hFFFF);
      end else begin
        e = q_frm.pop_front();
        check("frame_len", 64'(n), 64'(e.nbits));
        check("cipo_oe_pattern", 64'(oe_v), 64'(e.oe));
        if (e.chk) begin
          for (int j = 0; j < DW; j++) rd[DW-1-j] = ci_v[1+AW+j];
          check("read_data", 64'(rd), 64'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int addr, nb, rw;
    for (int k = 0; k < NR; k++) m_regs[k] = '0;

    #20;
    check("reset_regs", 64'(regs), 64'd0);
    check("reset_cipo", 64'(cipo), 64'd0);
    check("reset_cipo_oe", 64'(cipo_oe), 64'd0);
    check("reset_wr_strobe", 64'(wr_strobe), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    #20 rst_n = 1'b1;
    #200;

    do_write(2, 8'hA5, FW, 200, 1'b0);
    check_regs("regs_after_write_a5");
    do_read(2, FW, 200);

    do_write(9, 8'h3C, FW, 200, 1'b0);
    check_regs("regs_after_oor_write");
    do_read(9, FW, 200);

    do_write(1, 8'hFF, 10, 200, 1'b0);
    do_write(1, 8'hFF, FW + 1, 200, 1'b0);
    check_regs("regs_after_bad_length");

    do_write(3, 8'h77, 12, 200, 1'b1);
    check_regs("regs_after_reset_mid_frame");
    do_write(3, 8'h77, FW, 200, 1'b0);
    check_regs("regs_after_write_77");

    do_write(0, 8'h5A, FW, 40, 1'b0);
    do_write(4, 8'hC3, FW, 200, 1'b0);
    check_regs("regs_after_back_to_back");

    for (int t = 0; t < 40; t++) begin
      addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                         : int'($urandom_range(0, 6));
      nb   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 20)) : FW;
      rw   = int'($urandom_range(0, 1));
      if (rw != 0) do_write(addr, DW'($urandom), nb, 40 * int'($urandom_range(1, 5)), 1'b0);
      else         do_read(addr, nb, 40 * int'($urandom_range(1, 5)));
      check_regs("regs_random");
    end

    #300;
    check("pending_writes", 64'(q_wr.size()), 64'd0);
    check("pending_frames", 64'(q_frm.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
